usb_pkt_seq: RTL and testbench

//  Transmit-side packet sequencer in front of the CRC unit. Accepts one packet descriptor,

---
 rtl/usb_pkg.sv | 30 +++
 rtl/usb_pkt_shreg.sv | 45 ++++
 rtl/usb_pkt_seq.sv | 213 +++++++++++++++++++++
 tb/tb_usb_pkt_seq.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/usb_pkg.sv
`default_nettype none
// ============================================================================
// Module : usb_pkg
// Brief  : Shared types and constants for the USB transmit packet sequencer.
// Rev    : 1.0  initial release
// ============================================================================
package usb_pkg;

  // Packet flavour; selects body length and CRC width.
  typedef enum logic [1:0] {
    HSHAKE = 2'd0,   // PID only, no CRC
    TOKEN  = 2'd1,   // 11-bit body, CRC5
    DATA   = 2'd2    // byte payload, CRC16
  } pkt_kind_t;

  localparam logic [3:0] PID_OUT   = 4'b0001;
  localparam logic [3:0] PID_ACK   = 4'b0010;
  localparam logic [3:0] PID_DATA0 = 4'b0011;

  // SYNC as a shift image: bit 0 leaves first, so the line sees 0000_0001.
  localparam logic [7:0] SYNC_PAT = 8'h80;

  localparam int CRC5_LEN  = 5;
  localparam int CRC16_LEN = 16;
  localparam int EOP_LEN   = 2;
  localparam int HDR_BITS  = 16;   // SYNC + PID + ~PID
  localparam int TOK_BITS  = 11;

endpackage
`default_nettype wire

// File: rtl/usb_pkt_shreg.sv
`default_nettype none
// ============================================================================
// Module : usb_pkt_shreg
// Brief  : LSB-first load/shift register with a down-count of valid bits.
// Rev    : 1.0  initial release
// ============================================================================
module usb_pkt_shreg #(
  parameter int WIDTH = 80,
  parameter int CW    = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_data,
  input  logic [CW-1:0]    i_nbits,
  input  logic             i_shift,
  input  logic             i_stall,
  output logic             o_bit,
  output logic [CW-1:0]    o_bits_left
);

  logic [WIDTH-1:0] r_sr;
  logic [CW-1:0]    r_left;

  // Load a fresh image, or move one bit out on every non-stalled shift cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sr   <= '0;
      r_left <= '0;
    end else if (i_load) begin
      r_sr   <= i_data;
      r_left <= i_nbits;
    end else if (i_shift && !i_stall) begin
      r_sr <= {1'b0, r_sr[WIDTH-1:1]};
      if (r_left != '0) begin
        r_left <= r_left - 1'b1;
      end
    end
  end

  assign o_bit       = r_sr[0];
  assign o_bits_left = r_left;

endmodule
`default_nettype wire

// File: rtl/usb_pkt_seq.sv
`default_nettype none
// ============================================================================
// Module : usb_pkt_seq
// Brief  : Transmit packet sequencer feeding a serial CRC5/CRC16 unit.
//          SYNC -> PID -> BODY -> CRC -> EOP, stall-aware, one packet in flight.
// Rev    : 1.0  initial release
// ============================================================================
module usb_pkt_seq
  import usb_pkg::*;
#(
  parameter int MAX_BYTES = 8,
  parameter int LW        = $clog2(MAX_BYTES + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_pkt_valid,
  output logic                   o_pkt_ready,
  input  pkt_kind_t              i_pkt_kind,
  input  logic [3:0]             i_pid,
  input  logic [10:0]            i_tok_field,
  input  logic [LW-1:0]          i_data_len,
  input  logic [8*MAX_BYTES-1:0] i_data_in,
  input  logic                   i_abort,
  input  logic                   i_stall,
  output logic                   o_crc_inb,
  output logic                   o_crc_recving,
  output logic                   o_crc_start,
  output logic                   o_crc_pkttype,
  output logic                   o_crc_clear,
  output logic                   o_crc_pause_out,
  output logic                   o_eop,
  output logic                   o_done,
  output logic                   o_err
);

  localparam int SR_W = HDR_BITS + 8 * MAX_BYTES;
  localparam int CW   = $clog2(SR_W + 1);

  localparam logic [LW-1:0] c_MAX_LEN = LW'(MAX_BYTES);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_SYNC = 3'd1;
  localparam logic [2:0] S_PID  = 3'd2;
  localparam logic [2:0] S_BODY = 3'd3;
  localparam logic [2:0] S_CRC  = 3'd4;
  localparam logic [2:0] S_EOP  = 3'd5;

  logic [2:0] r_state;
  logic [4:0] r_cnt;       // bits/cycles left in the current phase, minus one
  logic       r_pkttype;   // 1 = CRC16 packet
  logic       r_hshake;    // no body and no CRC phase
  logic       r_err;
  logic       r_clear;

  logic                   w_accept;
  logic                   w_reject;
  logic [CW-1:0]          w_body_bits;
  logic [8*MAX_BYTES-1:0] w_body;
  logic [SR_W-1:0]        w_img;
  logic                   w_in_hdr;
  logic                   w_in_ser;
  logic                   w_sr_bit;
  logic [CW-1:0]          w_bits_left;

  assign w_accept = i_pkt_valid && (r_state == S_IDLE);
  assign w_in_hdr = (r_state == S_SYNC) || (r_state == S_PID);
  assign w_in_ser = w_in_hdr || (r_state == S_BODY);

  // Decode the descriptor: body image, body length and validity.
  always_comb begin
    w_reject    = 1'b0;
    w_body      = '0;
    w_body_bits = '0;
    case (i_pkt_kind)
      HSHAKE: begin
        w_body      = '0;
        w_body_bits = '0;
      end
      TOKEN: begin
        w_body      = {{(8*MAX_BYTES-TOK_BITS){1'b0}}, i_tok_field};
        w_body_bits = CW'(TOK_BITS);
      end
      DATA: begin
        // Bytes beyond data_len are loaded but never reach the line.
        w_body      = i_data_in;
        w_body_bits = CW'(i_data_len) << 3;
        w_reject    = (i_data_len == '0) || (i_data_len > c_MAX_LEN);
      end
      default: begin
        w_reject = 1'b1;
      end
    endcase
  end

  assign w_img = {w_body, ~i_pid, i_pid, SYNC_PAT};

  usb_pkt_shreg #(
    .WIDTH (SR_W),
    .CW    (CW)
  ) u_shreg (
    .clk         (clk),
    .rst         (rst),
    .i_load      (w_accept && !w_reject),
    .i_data      (w_img),
    .i_nbits     (CW'(HDR_BITS) + w_body_bits),
    .i_shift     (w_in_ser),
    .i_stall     (i_stall),
    .o_bit       (w_sr_bit),
    .o_bits_left (w_bits_left)
  );

  // Phase sequencing; abort beats stall, EOP runs regardless of stall.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_pkttype <= 1'b0;
      r_hshake  <= 1'b0;
      r_err     <= 1'b0;
      r_clear   <= 1'b0;
    end else begin
      r_err   <= 1'b0;
      r_clear <= 1'b0;
      if ((r_state != S_IDLE) && i_abort) begin
        r_state <= S_IDLE;
        r_cnt   <= '0;
        r_err   <= 1'b1;
        r_clear <= 1'b1;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (w_accept) begin
              if (w_reject) begin
                r_err <= 1'b1;
              end else begin
                r_state   <= S_SYNC;
                r_cnt     <= 5'd7;
                r_pkttype <= (i_pkt_kind == DATA);
                r_hshake  <= (i_pkt_kind == HSHAKE);
              end
            end
          end
          S_SYNC: begin
            if (!i_stall) begin
              if (r_cnt == '0) begin
                r_state <= S_PID;
                r_cnt   <= 5'd7;
              end else begin
                r_cnt <= r_cnt - 1'b1;
              end
            end
          end
          S_PID: begin
            if (!i_stall) begin
              if (r_cnt == '0) begin
                if (r_hshake) begin
                  r_state <= S_EOP;
                  r_cnt   <= 5'(EOP_LEN - 1);
                end else begin
                  r_state <= S_BODY;
                  r_cnt   <= '0;
                end
              end else begin
                r_cnt <= r_cnt - 1'b1;
              end
            end
          end
          S_BODY: begin
            // The shifter's valid-bit count marks the last body bit.
            if (!i_stall && (w_bits_left == CW'(1))) begin
              r_state <= S_CRC;
              r_cnt   <= r_pkttype ? 5'(CRC16_LEN - 1) : 5'(CRC5_LEN - 1);
            end
          end
          S_CRC: begin
            if (!i_stall) begin
              if (r_cnt == '0) begin
                r_state <= S_EOP;
                r_cnt   <= 5'(EOP_LEN - 1);
              end else begin
                r_cnt <= r_cnt - 1'b1;
              end
            end
          end
          S_EOP: begin
            if (r_cnt == '0) begin
              r_state <= S_IDLE;
            end else begin
              r_cnt <= r_cnt - 1'b1;
            end
          end
          default: begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
          end
        endcase
      end
    end
  end

  assign o_pkt_ready     = (r_state == S_IDLE);
  assign o_crc_inb       = w_sr_bit && w_in_ser;
  assign o_crc_recving   = w_in_ser;
  assign o_crc_start     = w_in_hdr;
  assign o_crc_pkttype   = r_pkttype && (r_state != S_IDLE);
  assign o_crc_clear     = r_clear;
  assign o_crc_pause_out = i_stall;
  assign o_eop           = (r_state == S_EOP);
  assign o_done          = (r_state == S_EOP) && (r_cnt == '0);
  assign o_err           = r_err;

endmodule
`default_nettype wire

// File: tb/tb_usb_pkt_seq.sv
`default_nettype none
// ============================================================================
// Module : tb_usb_pkt_seq
// Brief  : Directed self-checking bench for usb_pkt_seq.
// Rev    : 1.0  initial release
// ============================================================================
module tb_usb_pkt_seq;
  import usb_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_pkt_valid;
  logic        o_pkt_ready;
  pkt_kind_t   i_pkt_kind;
  logic [3:0]  i_pid;
  logic [10:0] i_tok_field;
  logic [3:0]  i_data_len;
  logic [63:0] i_data_in;
  logic        i_abort;
  logic        i_stall;
  logic        o_crc_inb, o_crc_recving, o_crc_start, o_crc_pkttype;
  logic        o_crc_clear, o_crc_pause_out, o_eop, o_done, o_err;

  int n_vec = 0;
  int n_err = 0;

  logic [127:0] inb_seq, exp_seq;
  int done_cyc, start_n, recv_n, eop_n, eop_first, pt_n, crc_n, pause_bad;
  int exp_done, exp_body, exp_crc;
  int mon_done, mon_eop, mon_recv;

  usb_pkt_seq #(.MAX_BYTES(8)) dut (
    .clk             (clk),
    .rst             (rst),
    .i_pkt_valid     (i_pkt_valid),
    .o_pkt_ready     (o_pkt_ready),
    .i_pkt_kind      (i_pkt_kind),
    .i_pid           (i_pid),
    .i_tok_field     (i_tok_field),
    .i_data_len      (i_data_len),
    .i_data_in       (i_data_in),
    .i_abort         (i_abort),
    .i_stall         (i_stall),
    .o_crc_inb       (o_crc_inb),
    .o_crc_recving   (o_crc_recving),
    .o_crc_start     (o_crc_start),
    .o_crc_pkttype   (o_crc_pkttype),
    .o_crc_clear     (o_crc_clear),
    .o_crc_pause_out (o_crc_pause_out),
    .o_eop           (o_eop),
    .o_done          (o_done),
    .o_err           (o_err)
  );

  always #5 clk = ~clk;

  // {ready, inb, recving, start, pkttype, clear, pause, eop, done, err}
  function automatic logic [9:0] outs();
    return {o_pkt_ready, o_crc_inb, o_crc_recving, o_crc_start, o_crc_pkttype,
            o_crc_clear, o_crc_pause_out, o_eop, o_done, o_err};
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one descriptor for one edge; on return the bench is in cycle 1.
  task automatic send(input pkt_kind_t k, input logic [3:0] p, input logic [10:0] t,
                      input logic [3:0] len, input logic [63:0] d);
    i_pkt_valid = 1'b1;
    i_pkt_kind  = k;
    i_pid       = p;
    i_tok_field = t;
    i_data_len  = len;
    i_data_in   = d;
    step();
    i_pkt_valid = 1'b0;
  endtask

  // Reference line image: SYNC, PID, ~PID, body, CRC zeros, with stall holds.
  task automatic build_exp(input pkt_kind_t k, input logic [3:0] p, input logic [10:0] t,
                           input int len, input logic [63:0] d,
                           input int st_at, input int st_len);
    logic [127:0] s;
    logic [7:0]   sy;
    int           pos, total;
    s  = '0;
    sy = 8'b1000_0000;
    for (int i = 0; i < 8; i++) s[i] = sy[i];
    for (int i = 0; i < 4; i++) begin
      s[8+i]  = p[i];
      s[12+i] = ~p[i];
    end
    exp_body = (k == TOKEN) ? 11 : (k == DATA) ? 8 * len : 0;
    exp_crc  = (k == TOKEN) ? 5 : (k == DATA) ? 16 : 0;
    for (int i = 0; i < exp_body; i++) s[16+i] = (k == TOKEN) ? t[i] : d[i];
    total   = 16 + exp_body + exp_crc;
    exp_seq = '0;
    pos     = 0;
    for (int c = 1; c <= total + st_len; c++) begin
      exp_seq[c] = s[pos];
      if (!(c >= st_at && c < st_at + st_len)) pos++;
    end
    exp_done = total + st_len + 2;
  endtask

  // Observe the packet from cycle 1 until done (bounded), applying the stall window.
  task automatic capture(input int st_at, input int st_len);
    inb_seq = '0; done_cyc = 0; start_n = 0; recv_n = 0; eop_n = 0;
    eop_first = 0; pt_n = 0; crc_n = 0; pause_bad = 0;
    for (int c = 1; c <= 120; c++) begin
      i_stall = (c >= st_at && c < st_at + st_len);
      #1;
      inb_seq[c] = o_crc_inb;
      start_n   += int'(o_crc_start);
      recv_n    += int'(o_crc_recving);
      eop_n     += int'(o_eop);
      pt_n      += int'(o_crc_pkttype);
      if (o_eop && eop_first == 0) eop_first = c;
      if (!o_crc_recving && !o_crc_start && !o_eop && !o_pkt_ready) crc_n++;
      if (o_crc_pause_out !== i_stall) pause_bad++;
      if (o_done) done_cyc = c;
      step();
      if (done_cyc != 0) break;
    end
    i_stall = 1'b0;
    #1;
    if (done_cyc == 0) begin
      n_vec++;
      n_err++;
      $error("FAIL done_timeout: observed no done expected done within 120 cycles");
    end
  endtask

  task automatic check_pkt(input string nm, input int st_len, input bit is_data);
    chk({nm, "_inb_seq"},   inb_seq, exp_seq);
    chk({nm, "_done_cyc"},  done_cyc, exp_done);
    chk({nm, "_start_n"},   start_n, 16);
    chk({nm, "_recv_n"},    recv_n, 16 + exp_body + st_len);
    chk({nm, "_crc_n"},     crc_n, exp_crc);
    chk({nm, "_eop_n"},     eop_n, 2);
    chk({nm, "_eop_first"}, eop_first, exp_done - 1);
    chk({nm, "_pkttype_n"}, pt_n, is_data ? exp_done : 0);
    chk({nm, "_pause"},     pause_bad, 0);
    chk({nm, "_post_idle"}, {o_pkt_ready, o_eop, o_done}, 3'b100);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; i_pkt_valid = 1'b0; i_pkt_kind = HSHAKE; i_pid = '0;
    i_tok_field = '0; i_data_len = '0; i_data_in = '0; i_abort = 1'b0; i_stall = 1'b0;
    step(); step();
    chk("reset_outs", outs(), 10'b10_0000_0000);
    rst = 1'b0;
    step();
    chk("idle_outs", outs(), 10'b10_0000_0000);

    // HSHAKE / ACK
    send(HSHAKE, PID_ACK, 11'd0, 4'd0, 64'd0);
    build_exp(HSHAKE, PID_ACK, 11'd0, 0, 64'd0, 0, 0);
    capture(0, 0);
    chk("hs_bits_lit", inb_seq[16:1], 16'hD280);
    chk("hs_done_lit", done_cyc, 18);
    check_pkt("hs", 0, 1'b0);

    // TOKEN / OUT, addr 5, endp 0
    send(TOKEN, PID_OUT, {4'd0, 7'd5}, 4'd0, 64'd0);
    build_exp(TOKEN, PID_OUT, {4'd0, 7'd5}, 0, 64'd0, 0, 0);
    capture(0, 0);
    chk("tok_body_lit", inb_seq[27:17], 11'd5);
    chk("tok_done_lit", done_cyc, 34);
    check_pkt("tok", 0, 1'b0);

    // DATA0, two bytes; upper bytes are junk that must not appear
    send(DATA, PID_DATA0, 11'd0, 4'd2, 64'hFFFF_FFFF_FFFF_A55A);
    build_exp(DATA, PID_DATA0, 11'd0, 2, 64'hFFFF_FFFF_FFFF_A55A, 0, 0);
    capture(0, 0);
    chk("dat_body_lit", inb_seq[32:17], 16'hA55A);
    chk("dat_done_lit", done_cyc, 50);
    check_pkt("dat", 0, 1'b1);

    // Same DATA0 with a 3-cycle stall on the fifth body bit (cycle 21)
    send(DATA, PID_DATA0, 11'd0, 4'd2, 64'h0000_0000_0000_A55A);
    build_exp(DATA, PID_DATA0, 11'd0, 2, 64'h0000_0000_0000_A55A, 21, 3);
    capture(21, 3);
    chk("stl_hold_lit", inb_seq[25:21], 5'b01111);
    chk("stl_done_lit", done_cyc, 53);
    check_pkt("stl", 3, 1'b1);

    // Abort during BODY (cycle 20)
    send(DATA, PID_DATA0, 11'd0, 4'd2, 64'h0000_0000_0000_A55A);
    repeat (19) step();
    chk("abt_in_body", {o_crc_recving, o_crc_start}, 2'b10);
    i_abort = 1'b1;
    step();
    i_abort = 1'b0;
    chk("abt_outs", outs(), 10'b10_0001_0001);
    step();
    chk("abt_after", outs(), 10'b10_0000_0000);
    mon_done = 0; mon_eop = 0;
    for (int c = 0; c < 40; c++) begin
      mon_done += int'(o_done);
      mon_eop  += int'(o_eop);
      step();
    end
    chk("abt_no_done", mon_done, 0);
    chk("abt_no_eop", mon_eop, 0);

    // Abort while idle is ignored
    i_abort = 1'b1;
    step();
    i_abort = 1'b0;
    chk("abt_idle", outs(), 10'b10_0000_0000);

    // Rejected DATA lengths 0 and 9
    send(DATA, PID_DATA0, 11'd0, 4'd0, 64'h1234);
    chk("rej0_err", outs(), 10'b10_0000_0001);
    mon_recv = 0;
    for (int c = 0; c < 5; c++) begin
      step();
      mon_recv += int'(o_crc_recving) + int'(o_err);
    end
    chk("rej0_quiet", mon_recv, 0);
    send(DATA, PID_DATA0, 11'd0, 4'd9, 64'h1234);
    chk("rej9_err", outs(), 10'b10_0000_0001);
    mon_recv = 0;
    for (int c = 0; c < 5; c++) begin
      step();
      mon_recv += int'(o_crc_recving) + int'(o_err);
    end
    chk("rej9_quiet", mon_recv, 0);

    // Reset in the middle of the TOKEN CRC phase (cycle 30)
    send(TOKEN, PID_OUT, {4'd0, 7'd5}, 4'd0, 64'd0);
    repeat (29) step();
    chk("rst_in_crc", {o_pkt_ready, o_crc_recving, o_crc_start, o_eop}, 4'b0000);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst_outs", outs(), 10'b10_0000_0000);

    // Recovery after reset: a handshake goes through normally
    step();
    send(HSHAKE, PID_ACK, 11'd0, 4'd0, 64'd0);
    build_exp(HSHAKE, PID_ACK, 11'd0, 0, 64'd0, 0, 0);
    capture(0, 0);
    chk("rec_bits", inb_seq, exp_seq);
    chk("rec_done", done_cyc, 18);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
